minterm_sweep_checker: RTL and testbench

- Parametrised, self-checking exhaustive-stimulus engine for N-input single-output combinational blocks.
- Walks all 2^N input vectors, holds each for DWELL cycles, and samples the DUT output at the end of each window.
- Compares each sample against a golden truth-table parameter and reports pass/fail, error count and first failing vector.
- Replaces hand-written per-vector initial blocks with a synthesizable, reusable sequencer for lab checkers.

---
 rtl/minterm_sweep_checker.sv | 119 +++++++++++
 tb/tb_minterm_sweep_checker.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/minterm_sweep_checker.sv
// Exhaustive-stimulus sequencer: walks all 2^N input vectors, holds each for DWELL cycles,
// compares the DUT output against TRUTH. Define MINTERM_SWEEP_GRAY_ORDER_EN for Gray order.
module minterm_sweep_checker #(
  parameter int                N     = 4,
  parameter int                DWELL = 10,
  parameter logic [(1<<N)-1:0] TRUTH = 16'h6996
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dut_out,
  output logic [N-1:0] dut_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic [N-1:0] first_err_vec,
  output logic         first_err_valid
);

  localparam int             DW         = $clog2(DWELL) + 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N-1:0]   IDX_LAST   = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_r;
  logic [N-1:0]  idx_r;
  logic [DW-1:0] dwell_r;

  logic          mismatch_s;
  logic [N:0]    err_next_s;
  logic [N-1:0]  idx_next_s;

  // Sweep order: binary index, or its reflected Gray code.
  function automatic logic [N-1:0] vec(input logic [N-1:0] i);
`ifdef MINTERM_SWEEP_GRAY_ORDER_EN
    vec = i ^ (i >> 1);
`else
    vec = i;
`endif
  endfunction

  // Compare against the registered stimulus so TRUTH is indexed by the applied vector.
  always_comb begin
    mismatch_s = (dut_out != TRUTH[dut_in]);
    err_next_s = err_cnt + (mismatch_s ? (N+1)'(1) : (N+1)'(0));
    idx_next_s = idx_r + N'(1);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      idx_r           <= '0;
      dwell_r         <= '0;
      dut_in          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r         <= APPLY;
            idx_r           <= '0;
            dut_in          <= vec('0);
            dwell_r         <= DWELL_LAST;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        APPLY: begin
          if (dwell_r != '0) begin
            dwell_r <= dwell_r - DW'(1);
          end else begin
            err_cnt <= err_next_s;
            if (mismatch_s && !first_err_valid) begin
              first_err_vec   <= dut_in;
              first_err_valid <= 1'b1;
            end else begin
              first_err_valid <= first_err_valid;
            end
            // The final sample's result is folded into pass on the same edge.
            if (idx_r == IDX_LAST) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_next_s == '0);
            end else begin
              idx_r   <= idx_next_s;
              dut_in  <= vec(idx_next_s);
              dwell_r <= DWELL_LAST;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Self-checking bench for minterm_sweep_checker (default N=4, DWELL=10, TRUTH=16'h6996);
// the DUT under test is a lookup table chosen per run, checked against a truth-table reference.
module tb_minterm_sweep_checker;

  localparam int          N     = 4;
  localparam int          DWELL = 10;
  localparam int          NV    = 1 << N;
  localparam logic [15:0] TRUTH = 16'h6996;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         dut_out;
  logic [N-1:0] dut_in;
  logic         busy, done, pass;
  logic [N:0]   err_cnt;
  logic [N-1:0] first_err_vec;
  logic         first_err_valid;

  logic [15:0]  actual_tbl = 16'h6996;
  int           checks = 0;
  int           errors = 0;

  assign dut_out = actual_tbl[dut_in];

  minterm_sweep_checker #(.N(N), .DWELL(DWELL), .TRUTH(TRUTH)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out), .dut_in(dut_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_vec(input int i);
`ifdef MINTERM_SWEEP_GRAY_ORDER_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  // Reference: which vectors disagree with TRUTH, and the first one met in sweep order.
  task automatic expect_result(output int exp_cnt, output int exp_first, output int exp_fv);
    exp_cnt = 0; exp_first = 0; exp_fv = 0;
    for (int i = 0; i < NV; i++) begin
      int v;
      v = ref_vec(i);
      if (actual_tbl[v] != TRUTH[v]) begin
        if (exp_fv == 0) begin
          exp_first = v;
          exp_fv = 1;
        end
        exp_cnt++;
      end
    end
  endtask

  task automatic run_sweep(input logic poke_mid);
    int ec, ef, efv;
    expect_result(ec, ef, efv);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_value("start_clears_done", int'(done), 0);
    check_value("start_clears_pass", int'(pass), 0);
    check_value("start_clears_err", int'(err_cnt), 0);
    check_value("start_clears_fev", int'(first_err_valid), 0);
    for (int k = 0; k < NV * DWELL; k++) begin
      check_value("seq_dut_in", int'(dut_in), ref_vec(k / DWELL));
      check_value("seq_busy", int'(busy), 1);
      check_value("seq_done", int'(done), 0);
      if (poke_mid && k == 40) start = 1'b1;
      else start = 1'b0;
      tick();
    end
    start = 1'b0;
    check_value("end_done", int'(done), 1);
    check_value("end_busy", int'(busy), 0);
    check_value("end_pass", int'(pass), (ec == 0) ? 1 : 0);
    check_value("end_err_cnt", int'(err_cnt), ec);
    check_value("end_fev", int'(first_err_valid), efv);
    if (efv != 0) check_value("end_first_vec", int'(first_err_vec), ef);
    check_value("end_dut_in", int'(dut_in), ref_vec(NV - 1));
    repeat (5) tick();
    check_value("hold_done", int'(done), 1);
    check_value("hold_err_cnt", int'(err_cnt), ec);
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_dut_in"}, int'(dut_in), 0);
    check_value({tag, "_busy"}, int'(busy), 0);
    check_value({tag, "_done"}, int'(done), 0);
    check_value({tag, "_pass"}, int'(pass), 0);
    check_value({tag, "_err"}, int'(err_cnt), 0);
    check_value({tag, "_fev"}, int'(first_err_valid), 0);
    check_value({tag, "_fvec"}, int'(first_err_vec), 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    repeat (20) tick();
    check_all_zero("idle");

    // Golden parity DUT, with a start pulse mid-run that must be ignored.
    actual_tbl = 16'h6996;
    run_sweep(1'b1);

    // Stuck-at-0 DUT, started again from DONE.
    actual_tbl = 16'h0000;
    run_sweep(1'b0);

    // DUT wrong on vector 3 only.
    actual_tbl = 16'h6996 ^ 16'h0008;
    run_sweep(1'b0);

    // Mid-sweep asynchronous reset at k=55.
    actual_tbl = 16'h6996;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (55) tick();
    check_value("pre_rst_dut_in", int'(dut_in), ref_vec(5));
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (done || busy) check_value("aborted_idle", int'(done) + int'(busy), 0);
    end
    check_all_zero("after_abort");
    run_sweep(1'b0);

    // Random DUT tables.
    for (int r = 0; r < 6; r++) begin
      actual_tbl = 16'($urandom);
      if (r == 0) actual_tbl = ~TRUTH;
      run_sweep(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
